fp_sub_seq: RTL and testbench
=============================

// Module: fp_sub_seq
// PURPOSE
//  Multi-cycle floating-point subtractor: result = X - Y in the same sign/exp/mantissa format as the FP add path.
//  Iterative: aligns one bit/cycle, normalizes one bit/cycle; handles full cancellation and renormalization.
//  Sits beside the FP adder in the execute stage; valid/ready on both sides so the pipeline can stall it.
// PARAMETERS
//  E       8            exponent bits
//  M       23           stored mantissa bits (hidden 1 implicit)
//  BITS    1+E+M        operand/result width
//  EB      2^(E-1)-1    exponent bias
//  MAXEXP  2*EB+1       all-ones exponent (Inf/NaN)
// PORTS
//  clk        in   1     clock
//  resetn     in   1     synchronous reset, active low
//  in_valid   in   1     X/Y valid
//  in_ready   out  1     unit can accept (high only in IDLE)
//  X          in   BITS  minuend
//  Y          in   BITS  subtrahend
//  out_valid  out  1     result/flags valid
//  out_ready  in   1     consumer accepts
//  result     out  BITS  X - Y
//  zero       out  1     result is +0
//  underflow  out  1     normalization fell below exp 1; flushed to +0
//  overflow   out  1     exponent reached MAXEXP; result = signed Inf
//  nan        out  1     either input exp==MAXEXP; result = 0x7FC00000-style quiet NaN
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-low (resetn). Reset: state IDLE, in_ready=1, out_valid=0, result/flags=0.
//  - Reset mid-operation abandons the op; no output produced.
//  - Accept on in_valid&&in_ready; operands captured, Y sign inverted (compute X + (-Y)).
//  - exp==0 inputs flushed to zero (no denormals). Any exp==MAXEXP -> DONE next cycle, nan=1.
//  - Larger magnitude ({exp,mant} compare) = A, smaller = B; result sign = A sign. Equal magnitudes, opposite effective signs -> +0.
//  - Working mantissas M+2 bits: {carry, hidden 1, M}. Truncation, no rounding.
//  - FSM: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
//    ALIGN: B mantissa >>1 per cycle, diff-1; leave when diff==0 or B mantissa==0; max(1,min(diff,M+2)) cycles.
//    ADD: 1 cycle; same effective sign add, else A-B (never negative by construction).
//    NORM: carry set -> >>1, exp+1 (one cycle); else while hidden bit 0: <<1, exp-1 per cycle.
//      mantissa==0 -> +0, zero=1. exp would drop below 1 -> +0, underflow=1, zero=1.
//      exp reaches MAXEXP -> Inf, overflow=1. Occupies shifts+1 cycles.
//    DONE: out_valid=1; result/flags held stable until out_valid&&out_ready, then IDLE.
//  - Latency (accept edge to out_valid): equal exponents, no shift = 4 cycles; specials = 1 cycle;
//    worst case ~2M+8. No new accept before handshake completes (in_ready=0 outside IDLE).
//  - Flags valid only with out_valid; cleared on leaving DONE.
// STRUCTURE
//  - fp_pkg: state enum (IDLE/ALIGN/ADD/NORM/DONE), field-extract functions (sign/exp/mant),
//    NaN/Inf constant builders parameterized on E/M.
//  - Sub-module fp_unpack: combinational split of BITS into sign/exp/{1,mant} with zero/special detect;
//    instantiated twice. Datapath + FSM in this module.
// TESTING (E=8, M=23)
//  - 3.0-1.0: X=0x40400000 Y=0x3F800000 -> result=0x40000000, flags 0, out_valid 4 cycles after accept.
//  - 1.0-1.0: X=Y=0x3F800000 -> 0x00000000, zero=1; 1.0-(-1.0): Y=0xBF800000 -> 0x40000000.
//  - NaN: X=0x7FC00000 Y=0x3F800000 -> nan=1, out_valid 1 cycle after accept.
//  - Overflow: X=0x7F7FFFFF Y=0xFF7FFFFF -> 0x7F800000, overflow=1.
//  - Underflow: X=0x00800001 Y=0x00800000 -> 0x00000000, underflow=1, zero=1.
//  - Backpressure/reset: hold out_ready=0 10 cycles -> result stable, in_ready=0; resetn=0 mid-ALIGN -> IDLE, no out_valid.

Source files
------------

// File: rtl/fp_sub_seq_pkg.sv
// Shared constants, FSM state codes and field helpers for the sequential FP subtractor.
package fp_sub_seq_pkg;

    localparam int E      = 8;
    localparam int M      = 23;
    localparam int BITS   = 32'sd1 + E + M;
    localparam int EB     = (32'sd1 <<< (E - 32'sd1)) - 32'sd1;
    localparam int MAXEXP = 32'sd2 * EB + 32'sd1;
    localparam int WM     = M + 32'sd2;

    localparam logic [E-1:0]  EXP_MAX   = E'(MAXEXP);
    localparam logic [E-1:0]  EXP_ZERO  = {E{1'b0}};
    localparam logic [E-1:0]  EXP_ONE   = {{(E-1){1'b0}}, 1'b1};
    localparam logic [WM-1:0] MANW_ZERO = {WM{1'b0}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic fp_sign(input logic [BITS-1:0] v);
        return v[BITS-1];
    endfunction

    function automatic logic [E-1:0] fp_exp(input logic [BITS-1:0] v);
        return v[BITS-2:M];
    endfunction

    function automatic logic [M-1:0] fp_mant(input logic [BITS-1:0] v);
        return v[M-1:0];
    endfunction

    // Positive quiet NaN: all-ones exponent, mantissa MSB set.
    function automatic logic [BITS-1:0] fp_qnan();
        return {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    endfunction

    function automatic logic [BITS-1:0] fp_inf(input logic s);
        return {s, {E{1'b1}}, {M{1'b0}}};
    endfunction

endpackage

// File: rtl/fp_sub_seq_unpack.sv
// Combinational operand split: sign, exponent, {hidden,mantissa}; exp==0 is flushed to zero.
module fp_sub_seq_unpack
    import fp_sub_seq_pkg::*;
(
    input  logic [BITS-1:0] op,
    output logic            sign,
    output logic [E-1:0]    expo,
    output logic [M:0]      man,
    output logic            is_zero,
    output logic            is_special
);

    assign sign       = fp_sign(op);
    assign expo       = fp_exp(op);
    assign is_zero    = (fp_exp(op) == EXP_ZERO);
    assign is_special = (fp_exp(op) == EXP_MAX);
    assign man        = is_zero ? {(M+1){1'b0}} : {1'b1, fp_mant(op)};

endmodule

// File: rtl/fp_sub_seq.sv
// Iterative X - Y: one-bit-per-cycle alignment and normalization, valid/ready on both sides.
module fp_sub_seq
    import fp_sub_seq_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] X,
    input  logic [BITS-1:0] Y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] result,
    output logic            zero,
    output logic            underflow,
    output logic            overflow,
    output logic            nan
);

    logic [2:0]      state_q, state_d;
    logic            sign_q, sign_d;
    logic            sub_q, sub_d;
    logic [E-1:0]    exp_q, exp_d;
    logic [E-1:0]    diff_q, diff_d;
    logic [WM-1:0]   ma_q, ma_d;
    logic [WM-1:0]   mb_q, mb_d;
    logic [BITS-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            underflow_q, underflow_d;
    logic            overflow_q, overflow_d;
    logic            nan_q, nan_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic            ux_sign, uy_sign, ux_zero, uy_zero, ux_special, uy_special;
    logic [E-1:0]    ux_exp, uy_exp;
    logic [M:0]      ux_man, uy_man;
    logic [E+M-1:0]  mag_x, mag_y;

    // Y enters with its sign flipped so the core only ever adds X + (-Y).
    fp_sub_seq_unpack u_unpack_x (
        .op(X), .sign(ux_sign), .expo(ux_exp), .man(ux_man),
        .is_zero(ux_zero), .is_special(ux_special)
    );

    fp_sub_seq_unpack u_unpack_y (
        .op({~Y[BITS-1], Y[BITS-2:0]}), .sign(uy_sign), .expo(uy_exp), .man(uy_man),
        .is_zero(uy_zero), .is_special(uy_special)
    );

    assign mag_x = ux_zero ? {(E+M){1'b0}} : {ux_exp, ux_man[M-1:0]};
    assign mag_y = uy_zero ? {(E+M){1'b0}} : {uy_exp, uy_man[M-1:0]};

    // Next-state and datapath: capture/swap, align B, add/subtract, normalize, hold result.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        exp_d       = exp_q;
        diff_d      = diff_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        result_d    = result_q;
        zero_d      = zero_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        nan_d       = nan_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sub_d = ux_sign ^ uy_sign;
                    if (ux_special || uy_special) begin
                        state_d     = ST_DONE;
                        result_d    = fp_qnan();
                        nan_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else if (mag_x >= mag_y) begin
                        state_d = ST_ALIGN;
                        sign_d  = ux_sign;
                        exp_d   = ux_exp;
                        diff_d  = ux_exp - uy_exp;
                        ma_d    = {1'b0, ux_man};
                        mb_d    = {1'b0, uy_man};
                    end else begin
                        state_d = ST_ALIGN;
                        sign_d  = uy_sign;
                        exp_d   = uy_exp;
                        diff_d  = uy_exp - ux_exp;
                        ma_d    = {1'b0, uy_man};
                        mb_d    = {1'b0, ux_man};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                // Stop early once B has shifted out entirely; otherwise one bit per cycle.
                if ((diff_q == EXP_ZERO) || (mb_q == MANW_ZERO)) begin
                    state_d = ST_ADD;
                end else begin
                    mb_d   = {1'b0, mb_q[WM-1:1]};
                    diff_d = diff_q - EXP_ONE;
                    if (diff_q == EXP_ONE) begin
                        state_d = ST_ADD;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ADD: begin
                // A has the larger magnitude, so A - B cannot go negative.
                state_d = ST_NORM;
                if (sub_q) begin
                    ma_d = ma_q - mb_q;
                end else begin
                    ma_d = ma_q + mb_q;
                end
            end
            ST_NORM: begin
                if (ma_q == MANW_ZERO) begin
                    state_d     = ST_DONE;
                    result_d    = {BITS{1'b0}};
                    zero_d      = 1'b1;
                    out_valid_d = 1'b1;
                end else if (ma_q[M+1]) begin
                    ma_d  = {1'b0, ma_q[WM-1:1]};
                    exp_d = exp_q + EXP_ONE;
                end else if (!ma_q[M]) begin
                    if (exp_q <= EXP_ONE) begin
                        state_d     = ST_DONE;
                        result_d    = {BITS{1'b0}};
                        zero_d      = 1'b1;
                        underflow_d = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        ma_d  = {ma_q[WM-2:0], 1'b0};
                        exp_d = exp_q - EXP_ONE;
                    end
                end else begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    if (exp_q == EXP_MAX) begin
                        result_d   = fp_inf(sign_q);
                        overflow_d = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_q, ma_q[M-1:0]};
                    end
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    result_d    = {BITS{1'b0}};
                    zero_d      = 1'b0;
                    underflow_d = 1'b0;
                    overflow_d  = 1'b0;
                    nan_d       = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            exp_q       <= EXP_ZERO;
            diff_q      <= EXP_ZERO;
            ma_q        <= MANW_ZERO;
            mb_q        <= MANW_ZERO;
            result_q    <= {BITS{1'b0}};
            zero_q      <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            nan_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            exp_q       <= exp_d;
            diff_q      <= diff_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            nan_q       <= nan_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign nan       = nan_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed + light random bench for fp_sub_seq against a leading-one based reference model.
module tb_fp_sub_seq;

    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, out_valid, out_ready;
    logic        zero, underflow, overflow, nan;
    logic [31:0] X, Y, result;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_chk = 0;
    logic armed = 1'b0;
    logic pending = 1'b0;

    logic [31:0] exp_res;
    logic        exp_z, exp_u, exp_o, exp_n;
    int          exp_lat;

    always #5 clk = ~clk;

    fp_sub_seq dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .underflow(underflow),
        .overflow(overflow), .nan(nan)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, got, want);
        end
    endtask

    // Reference: align in one step, add/subtract, then place the leading one.
    // Latency = align cycles + ADD + normalize cycles + 1 (cycle DONE becomes visible).
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic z, output logic u,
                                  output logic o, output logic n, output int lat);
        int ex, ey, ea, eb, d, a, nc, k, p;
        longint mx, my, ma, mb, s, magx, magy;
        logic sx, sy, sa, sub;
        logic [63:0] t;
        r = 32'h0; z = 1'b0; u = 1'b0; o = 1'b0; n = 1'b0;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if (ex == 255 || ey == 255) begin
            r = 32'h7FC00000; n = 1'b1; lat = 1;
            return;
        end
        sx = x[31];
        sy = ~y[31];
        sub = (sx != sy);
        mx = (ex == 0) ? 64'd0 : (64'd1 << 23) + longint'(x[22:0]);
        my = (ey == 0) ? 64'd0 : (64'd1 << 23) + longint'(y[22:0]);
        magx = (ex == 0) ? 64'd0 : longint'(x[30:0]);
        magy = (ey == 0) ? 64'd0 : longint'(y[30:0]);
        if (magx >= magy) begin
            sa = sx; ea = ex; ma = mx; eb = ey; mb = my;
        end else begin
            sa = sy; ea = ey; ma = my; eb = ex; mb = mx;
        end
        d = ea - eb;
        a = (d == 0 || mb == 0) ? 1 : ((d < 25) ? d : 25);
        mb = (d >= 25) ? 64'd0 : (mb >> d);
        s = sub ? ma - mb : ma + mb;
        t = 64'(s);
        if (s == 0) begin
            z = 1'b1; nc = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 26; i++) if (t[i]) p = i;
            if (p == 24) begin
                nc = 2;
                t = t >> 1;
                if (ea + 1 == 255) begin
                    o = 1'b1; r = {sa, 8'hFF, 23'h0};
                end else begin
                    r = {sa, 8'(ea + 1), t[22:0]};
                end
            end else begin
                k = 23 - p;
                if (ea - k >= 1) begin
                    nc = k + 1;
                    t = t << k;
                    r = {sa, 8'(ea - k), t[22:0]};
                end else begin
                    nc = ea; u = 1'b1; z = 1'b1;
                end
            end
        end
        lat = a + nc + 2;
    endfunction

    // Every cycle: result/flags must match the model while valid; nothing valid otherwise.
    always @(negedge clk) begin
        if (armed) begin
            if (!pending) begin
                chk("idle_out_valid", {63'b0, out_valid}, 64'd0);
            end else if (out_valid) begin
                chk("result", {32'b0, result}, {32'b0, exp_res});
                chk("flags", {60'b0, zero, underflow, overflow, nan}, {60'b0, exp_z, exp_u, exp_o, exp_n});
                chk("in_ready_busy", {63'b0, in_ready}, 64'd0);
            end else begin
                chk("flags_not_valid", {60'b0, zero, underflow, overflow, nan}, 64'd0);
            end
        end
    end

    task automatic run_vec(input logic [31:0] x, input logic [31:0] y, input logic pin,
                           input logic [31:0] lit_res, input int lit_lat, input int hold);
        int lat;
        int w;
        model(x, y, exp_res, exp_z, exp_u, exp_o, exp_n, exp_lat);
        if (pin) begin
            chk("model_pin_result", {32'b0, exp_res}, {32'b0, lit_res});
            chk("model_pin_latency", 64'(exp_lat), 64'(lit_lat));
        end
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", {63'b0, in_ready}, 64'd1);
        X = x; Y = y; in_valid = 1'b1;
        @(posedge clk);
        pending = 1'b1;
        n_vec++;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency %h-%h", x, y), 64'(lat), 64'(exp_lat));
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        pending = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rx, ry;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; X = 32'h0; Y = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_result", {32'b0, result}, 64'd0);
        chk("reset_flags", {60'b0, zero, underflow, overflow, nan}, 64'd0);
        resetn = 1'b1;
        armed = 1'b1;
        @(negedge clk);

        run_vec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4, 0);
        run_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4, 0);
        run_vec(32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 5, 0);
        run_vec(32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000, 1, 0);
        run_vec(32'h7F7FFFFF, 32'hFF7FFFFF, 1'b1, 32'h7F800000, 5, 0);
        run_vec(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4, 0);
        run_vec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4, 10);
        run_vec(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 27, 0);
        run_vec(32'h40A00000, 32'h3F000000, 1'b1, 32'h40900000, 6, 0);
        run_vec(32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 5, 0);
        run_vec(32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 28, 0);
        run_vec(32'h00000001, 32'h3F800000, 1'b1, 32'hBF800000, 4, 0);
        run_vec(32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 4, 0);
        run_vec(32'h3F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1, 0);
        run_vec(32'hC0000000, 32'h40000000, 1'b1, 32'hC0800000, 5, 2);

        for (int i = 0; i < 4; i++) begin
            rx = $urandom();
            ry = $urandom();
            run_vec(rx, ry, 1'b0, 32'h0, 0, 0);
            rx = $urandom();
            ry = rx ^ ($urandom() & 32'h0000FFFF);
            run_vec(rx, ry, 1'b0, 32'h0, 0, 1);
        end

        // Reset in the middle of a long alignment: the op must vanish.
        X = 32'h4B000000; Y = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk);
        n_vec++;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", {63'b0, in_ready}, 64'd0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("in_ready_after_reset", {63'b0, in_ready}, 64'd1);
        repeat (40) @(negedge clk);
        run_vec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
